// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the kFPGA tile configuration path.
// Holds the loader state encoding and the word-count helpers used by every loader instance.
package kfpga_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_READY  = 2'd3
  } cfg_state_e;

  // Number of bitstream words needed to cover a configuration vector.
  function automatic int unsigned cfg_nwords(input int unsigned config_width,
                                             input int unsigned word_width);
    return (config_width + word_width - 1) / word_width;
  endfunction

  // Word counter width; never below one bit so a single-word stream still has a counter.
  function automatic int unsigned cfg_cnt_width(input int unsigned nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/tile_config_loader.sv
// Streams a bitstream into a shadow register, then commits it to the tile in one cycle.
// state   | meaning
// IDLE    | no valid configuration committed since reset or abort
// LOAD    | accepting words into shadow
// COMMIT  | single cycle, shadow copied to config_out at its ending edge
// READY   | tile configured and enabled
module tile_config_loader
  import kfpga_config_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 524,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    tile_enable,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NWORDS = cfg_nwords(CONFIG_WIDTH, WORD_WIDTH);
  localparam int unsigned CNT_W  = cfg_cnt_width(NWORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  cfg_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;

  logic start_accept;
  logic abort_load;
  logic beat;
  logic last_beat;

  // Qualifiers: abort only matters in LOAD and suppresses any beat in the same cycle.
  assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_READY));
  assign abort_load   = abort && (state_q == ST_LOAD);
  assign beat         = data_valid && (state_q == ST_LOAD) && !abort;
  assign last_beat    = beat && (cnt_q == LAST_WORD);

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_beat) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_READY;
      end
      ST_READY: begin
        if (start) state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure state decodes so data_ready has no path from any input.
  always_comb begin
    data_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    tile_enable = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        data_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_COMMIT: begin
        busy = 1'b1;
      end
      ST_READY: begin
        done        = 1'b1;
        tile_enable = 1'b1;
      end
      default: begin
        data_ready = 1'b0;
      end
    endcase
  end

  // Word counter saturates on the last word rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (start_accept) begin
      cnt_d = '0;
    end else if (beat && !last_beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Each shadow bit belongs to exactly one word slot; bits of the final word past
  // CONFIG_WIDTH have no shadow bit and simply fall away.
  always_comb begin
    shadow_d = shadow_q;
    if (abort_load) begin
      shadow_d = '0;
    end else if (beat) begin
      for (int i = 0; i < int'(CONFIG_WIDTH); i++) begin
        if (cnt_q == CNT_W'(i / int'(WORD_WIDTH))) begin
          shadow_d[i] = data_in[i % int'(WORD_WIDTH)];
        end
      end
    end
  end

  // Active configuration only changes on the COMMIT edge.
  always_comb begin
    config_d = config_q;
    if (state_q == ST_COMMIT) begin
      config_d = shadow_q;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      config_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      config_q <= config_d;
    end
  end

  assign config_out = config_q;

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench for tile_config_loader: load, reconfigure, backpressure, ignored start,
// abort and asynchronous reset scenarios against hand-built expected configurations.
module tb_tile_config_loader;

  localparam int CW = 524;
  localparam int WW = 8;
  localparam int NW = 66;

  logic          clock;
  logic          nreset;
  logic          start;
  logic          abort;
  logic [WW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [CW-1:0] config_out;
  logic          tile_enable;
  logic          busy;
  logic          done;

  int tests_run;
  int tests_failed;

  logic [CW-1:0] exp_count;   // words 0x00..0x41
  logic [CW-1:0] exp_xor;     // words k ^ 0xC3
  logic [CW-1:0] exp_ones;

  tile_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .abort      (abort),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .config_out (config_out),
    .tile_enable(tile_enable),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected vector from a word sequence; bits beyond CW of the last word are dropped.
  function automatic logic [CW-1:0] build(input bit use_xor);
    logic [NW*WW-1:0] full;
    logic [WW-1:0]    w;
    full = '0;
    for (int k = 0; k < NW; k++) begin
      w = WW'(k);
      if (use_xor) w = w ^ 8'hC3;
      full[k*WW +: WW] = w;
    end
    return full[CW-1:0];
  endfunction

  initial begin
    int rdy_cycles;
    int k;
    tests_run    = 0;
    tests_failed = 0;
    exp_count    = build(1'b0);
    exp_xor      = build(1'b1);
    exp_ones     = '1;

    nreset     = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_config", config_out, '0);
    chk("rst_ready",  CW'(data_ready), '0);
    chk("rst_busy",   CW'(busy), '0);
    chk("rst_done",   CW'(done), '0);
    chk("rst_tile_en", CW'(tile_enable), '0);
    tick();
    nreset = 1'b1;
    tick();
    chk("idle_ready", CW'(data_ready), '0);

    // Basic load of 0x00..0x41
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready", CW'(data_ready), CW'(1));
    chk("load_busy",  CW'(busy), CW'(1));
    rdy_cycles = 0;
    for (int i = 0; i < NW; i++) begin
      data_valid = 1'b1;
      data_in    = WW'(i);
      if (data_ready) rdy_cycles++;
      tick();
    end
    data_valid = 1'b0;
    chk("ready_cycles", CW'(rdy_cycles), CW'(NW));
    chk("commit_busy",  CW'(busy), CW'(1));
    chk("commit_ready", CW'(data_ready), '0);
    chk("commit_done",  CW'(done), '0);
    chk("commit_cfg_old", config_out, '0);
    tick();
    chk("basic_done",   CW'(done), CW'(1));
    chk("basic_tile_en", CW'(tile_enable), CW'(1));
    chk("basic_busy",   CW'(busy), '0);
    chk("basic_byte0",  CW'(config_out[7:0]), CW'(8'h00));
    chk("basic_byte1",  CW'(config_out[15:8]), CW'(8'h01));
    chk("basic_top",    CW'(config_out[523:520]), CW'(4'h1));
    chk("basic_cfg",    config_out, exp_count);

    // Reconfigure with all ones; old config must persist until commit
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reconf_tile_en", CW'(tile_enable), '0);
    chk("reconf_done",    CW'(done), '0);
    for (int i = 0; i < NW; i++) begin
      data_valid = 1'b1;
      data_in    = 8'hFF;
      if (i == 33) begin
        chk("reconf_mid_cfg", config_out, exp_count);
        chk("reconf_mid_en",  CW'(tile_enable), '0);
      end
      tick();
    end
    data_valid = 1'b0;
    chk("reconf_commit_cfg", config_out, exp_count);
    abort = 1'b1;                       // must not disturb COMMIT
    tick();
    abort = 1'b0;
    chk("reconf_done2", CW'(done), CW'(1));
    chk("reconf_ones",  config_out, exp_ones);

    // Backpressure: every third cycle idle
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 300; c++) begin
      if (c % 3 == 2) begin
        data_valid = 1'b0;
      end else begin
        data_valid = 1'b1;
        data_in    = WW'(k);
      end
      if (c == 50) chk("bp_mid_cfg", config_out, exp_ones);
      tick();
      if (data_valid) k++;
      if (k == NW) break;
    end
    data_valid = 1'b0;
    chk("bp_words", CW'(k), CW'(NW));
    chk("bp_commit_busy", CW'(busy), CW'(1));
    tick();
    chk("bp_done", CW'(done), CW'(1));
    chk("bp_cfg",  config_out, exp_count);

    // Abort alone in READY is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ready_abort_done", CW'(done), CW'(1));

    // Start together with abort in READY: start wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("ready_start_load", CW'(data_ready), CW'(1));
    chk("ready_start_done", CW'(done), '0);
    chk("ready_start_en",   CW'(tile_enable), '0);
    chk("ready_start_cfg",  config_out, exp_count);

    // Start pulsed during LOAD at word 10 must be ignored
    for (int i = 0; i < NW; i++) begin
      data_valid = 1'b1;
      data_in    = WW'(i) ^ 8'hC3;
      start      = (i == 10);
      tick();
    end
    start      = 1'b0;
    data_valid = 1'b0;
    chk("ign_commit_busy",  CW'(busy), CW'(1));
    chk("ign_commit_ready", CW'(data_ready), '0);
    tick();
    chk("ign_done", CW'(done), CW'(1));
    chk("ign_cfg",  config_out, exp_xor);

    // Abort after 30 words, with a valid word on the abort cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      data_valid = 1'b1;
      data_in    = 8'h5A;
      tick();
    end
    abort      = 1'b1;
    data_in    = 8'h33;
    tick();
    abort      = 1'b0;
    data_valid = 1'b0;
    chk("abort_busy",  CW'(busy), '0);
    chk("abort_ready", CW'(data_ready), '0);
    chk("abort_done",  CW'(done), '0);
    chk("abort_en",    CW'(tile_enable), '0);
    chk("abort_cfg",   config_out, exp_xor);
    tick();
    chk("abort_idle_stays", CW'(busy), '0);

    // Start together with abort in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_start_abort", CW'(data_ready), CW'(1));

    // Asynchronous reset at word 40, checked before the next clock edge
    for (int i = 0; i < 40; i++) begin
      data_valid = 1'b1;
      data_in    = 8'h77;
      tick();
    end
    data_valid = 1'b0;
    nreset = 1'b0;
    #1;
    chk("arst_cfg",   config_out, '0);
    chk("arst_busy",  CW'(busy), '0);
    chk("arst_ready", CW'(data_ready), '0);
    chk("arst_done",  CW'(done), '0);
    chk("arst_en",    CW'(tile_enable), '0);
    tick();
    nreset = 1'b1;
    tick();
    chk("post_rst_cfg",  config_out, '0);
    chk("post_rst_busy", CW'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
